// File: rtl/linear_interpolator_pkg.sv
// Shared types and constants for the linear interpolator slice.
// Holds the ramp FSM state encoding and the default sample width.
package linear_interpolator_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } ramp_state_t;

    localparam int DEFAULT_IN_BITS = 16;
    localparam logic [15:0] OVERRUN_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/linear_interpolator_edge.sv
// Rising-edge detector for a slow strobe sampled in the clk domain.
// Reused by the other strobe consumers.
module strobe_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);

    logic cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 1'b0;
        end else begin
            cnt_q <= in;
        end
    end

    assign rise = in & ~cnt_q;

endmodule

// File: rtl/linear_interpolator.sv
// Upsampler: ramps linearly from the previous low-rate sample to the new one over 2^log2_steps clks.
// Optional overrun event counter enabled by defining LINEAR_INTERP_OVERRUN_CNT_EN.
module linear_interpolator
    import linear_interpolator_pkg::*;
#(
    parameter int in_bits    = DEFAULT_IN_BITS,
    parameter int out_bits   = 16,
    parameter int log2_steps = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cnt_clk,
    input  logic [in_bits-1:0]  in_data,
    output logic [out_bits-1:0] out_data,
    output logic                ramping,
    output logic                overrun
`ifdef LINEAR_INTERP_OVERRUN_CNT_EN
    ,
    output logic [15:0]         overrun_cnt
`endif
);

    localparam int ACC_W   = in_bits + log2_steps;
    localparam int DELTA_W = in_bits + 1;
    localparam logic [log2_steps-1:0] STEP_ONE  = 1;
    localparam logic [log2_steps-1:0] STEP_LAST = '1;

    ramp_state_t                state;
    ramp_state_t                state_next;
    logic                       cnt_edge;
    logic                       last_step;
    logic signed [ACC_W-1:0]    acc;
    logic signed [DELTA_W-1:0]  delta;
    logic signed [in_bits-1:0]  x_tgt;
    logic [log2_steps-1:0]      step_cnt;

    strobe_edge_detect u_edge (
        .clk  (clk),
        .rst  (rst),
        .in   (cnt_clk),
        .rise (cnt_edge)
    );

    assign last_step = (step_cnt == STEP_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A new edge always (re)starts a ramp, even on the final step.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (cnt_edge) state_next = RAMP;
            RAMP: if (!cnt_edge && last_step) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ramping = (state == RAMP);
    end

    // On overrun the accumulator snaps to the pending target so ramps never drift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      <= '0;
            delta    <= '0;
            x_tgt    <= '0;
            step_cnt <= '0;
            overrun  <= 1'b0;
        end else if (cnt_edge) begin
            if (state == RAMP) begin
                acc     <= {x_tgt, {log2_steps{1'b0}}};
                overrun <= 1'b1;
            end
            delta    <= DELTA_W'(signed'(in_data)) - DELTA_W'(x_tgt);
            x_tgt    <= signed'(in_data);
            step_cnt <= '0;
        end else if (state == RAMP) begin
            acc      <= acc + ACC_W'(delta);
            step_cnt <= step_cnt + STEP_ONE;
        end
    end

    assign out_data = acc[ACC_W-1 -: out_bits];

`ifdef LINEAR_INTERP_OVERRUN_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun_cnt <= '0;
        end else if (cnt_edge && state == RAMP && overrun_cnt != OVERRUN_CNT_MAX) begin
            overrun_cnt <= overrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_linear_interpolator.sv
// Testbench for linear_interpolator: two instances (4-step and 256-step ramps) share stimulus
// and are compared each cycle against a ramp-equation reference model.
module tb_linear_interpolator;

    logic               clk;
    logic               rst;
    logic               cnt_clk;
    logic signed [15:0] in_data;
    logic signed [15:0] out1;
    logic signed [15:0] out2;
    logic               ramp1;
    logic               ramp2;
    logic               ovr1;
    logic               ovr2;
`ifdef LINEAR_INTERP_OVERRUN_CNT_EN
    logic [15:0]        cnt1;
    logic [15:0]        cnt2;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: output = prev + j*(tgt-prev)/N, floored; prev is always the last target.
    int m_prev [2];
    int m_tgt  [2];
    int m_j    [2];
    int m_cnt  [2];
    bit m_busy [2];
    bit m_ovr  [2];
    bit m_cq;
    int steps  [2] = '{4, 256};
    int shifts [2] = '{2, 8};

    linear_interpolator #(.in_bits(16), .out_bits(16), .log2_steps(2)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .cnt_clk  (cnt_clk),
        .in_data  (in_data),
        .out_data (out1),
        .ramping  (ramp1),
        .overrun  (ovr1)
`ifdef LINEAR_INTERP_OVERRUN_CNT_EN
        ,
        .overrun_cnt (cnt1)
`endif
    );

    linear_interpolator #(.in_bits(16), .out_bits(16), .log2_steps(8)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .cnt_clk  (cnt_clk),
        .in_data  (in_data),
        .out_data (out2),
        .ramping  (ramp2),
        .overrun  (ovr2)
`ifdef LINEAR_INTERP_OVERRUN_CNT_EN
        ,
        .overrun_cnt (cnt2)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic signed [63:0] act,
                               input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int modelOut(input int i);
        longint a;
        a = longint'(m_prev[i]) * steps[i] + longint'(m_j[i]) * (m_tgt[i] - m_prev[i]);
        return int'(a >>> shifts[i]);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            m_prev[i] = 0;
            m_tgt[i]  = 0;
            m_j[i]    = 0;
            m_cnt[i]  = 0;
            m_busy[i] = 1'b0;
            m_ovr[i]  = 1'b0;
        end
        m_cq = 1'b0;
    endtask

    // Advance the model by the clock edge that will sample the current inputs.
    task automatic modelStep();
        bit e;
        e = cnt_clk && !m_cq;
        for (int i = 0; i < 2; i++) begin
            if (e) begin
                if (m_busy[i]) begin
                    m_ovr[i] = 1'b1;
                    if (m_cnt[i] < 65535) m_cnt[i]++;
                end
                m_prev[i] = m_tgt[i];
                m_tgt[i]  = int'(in_data);
                m_j[i]    = 0;
                m_busy[i] = 1'b1;
            end else if (m_busy[i]) begin
                m_j[i]++;
                if (m_j[i] == steps[i]) m_busy[i] = 1'b0;
            end
        end
        m_cq = cnt_clk;
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "/out1"},  out1,  modelOut(0));
        checkOutput({tag, "/ramp1"}, ramp1, m_busy[0]);
        checkOutput({tag, "/ovr1"},  ovr1,  m_ovr[0]);
        checkOutput({tag, "/out2"},  out2,  modelOut(1));
        checkOutput({tag, "/ramp2"}, ramp2, m_busy[1]);
        checkOutput({tag, "/ovr2"},  ovr2,  m_ovr[1]);
`ifdef LINEAR_INTERP_OVERRUN_CNT_EN
        checkOutput({tag, "/cnt1"}, cnt1, m_cnt[0]);
        checkOutput({tag, "/cnt2"}, cnt2, m_cnt[1]);
`endif
    endtask

    // Called at a negedge: drive inputs, let one posedge pass, check at the next negedge.
    task automatic applyStimulus(input logic c, input logic [15:0] d, input string tag);
        cnt_clk = c;
        in_data = d;
        modelStep();
        @(negedge clk);
        checkAll(tag);
    endtask

    // Async reset pulse placed mid low-phase, checked before any clock edge.
    task automatic asyncReset(input string tag);
        #1 rst = 1'b0;
        modelReset();
        #1;
        checkOutput({tag, "/out1_0"},  out1,  0);
        checkOutput({tag, "/ramp1_0"}, ramp1, 0);
        checkOutput({tag, "/ovr1_0"},  ovr1,  0);
        checkOutput({tag, "/out2_0"},  out2,  0);
        checkOutput({tag, "/ramp2_0"}, ramp2, 0);
`ifdef LINEAR_INTERP_OVERRUN_CNT_EN
        checkOutput({tag, "/cnt1_0"}, cnt1, 0);
        checkOutput({tag, "/cnt2_0"}, cnt2, 0);
`endif
        #1 rst = 1'b1;
    endtask

    initial begin
        int exp_t1 [4] = '{25, 50, 75, 100};
        int exp_t2 [4] = '{50, 0, -50, -100};
        int exp_t3 [4] = '{75, 50, 25, 0};
        logic signed [15:0] p1;
        logic signed [15:0] p2;

        rst     = 1'b0;
        cnt_clk = 1'b0;
        in_data = '0;
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("reset/out1",  out1,  0);
        checkOutput("reset/ramp1", ramp1, 0);
        checkOutput("reset/ovr1",  ovr1,  0);
        rst = 1'b1;

        $display("[TB] ramp 0 -> 100");
        applyStimulus(1'b1, 16'd100, "t1_edge");
        checkOutput("t1_start", out1, 0);
        checkOutput("t1_ramping", ramp1, 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 16'd7, "t1");
            checkOutput("t1_val", out1, exp_t1[i]);
            checkOutput("t1_ramp", ramp1, (i < 3) ? 1 : 0);
        end
        checkOutput("t1_ovr", ovr1, 0);

        $display("[TB] ramp 100 -> -100");
        applyStimulus(1'b1, -16'sd100, "t2_edge");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 16'd0, "t2");
            checkOutput("t2_val", out1, exp_t2[i]);
        end

        $display("[TB] overrun snap");
        asyncReset("t3_rst");
        applyStimulus(1'b1, 16'd100, "t3_edge1");
        applyStimulus(1'b0, 16'd100, "t3_a");
        checkOutput("t3_25", out1, 25);
        applyStimulus(1'b1, 16'd0, "t3_edge2");
        checkOutput("t3_snap", out1, 100);
        checkOutput("t3_ovr", ovr1, 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 16'd0, "t3");
            checkOutput("t3_val", out1, exp_t3[i]);
        end

        $display("[TB] held strobe");
        applyStimulus(1'b1, 16'd500, "t4_edge");
        for (int i = 0; i < 19; i++) applyStimulus(1'b1, 16'($urandom), "t4_hold");
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 16'($urandom), "t4_low");
        checkOutput("t4_final", out1, 500);
        checkOutput("t4_idle", ramp1, 0);

        $display("[TB] extremes");
        asyncReset("t5_rst");
        applyStimulus(1'b1, 16'h8000, "t5_edge1");
        for (int i = 0; i < 259; i++) applyStimulus(1'b0, 16'd0, "t5_settle");
        checkOutput("t5_min1", out1, -32768);
        checkOutput("t5_min2", out2, -32768);
        applyStimulus(1'b1, 16'h7FFF, "t5_edge2");
        for (int i = 0; i < 258; i++) begin
            p1 = out1;
            p2 = out2;
            applyStimulus(1'b0, 16'd0, "t5");
            checkOutput("t5_mono1", (out1 >= p1), 1);
            checkOutput("t5_mono2", (out2 >= p2), 1);
        end
        checkOutput("t5_max1", out1, 32767);
        checkOutput("t5_max2", out2, 32767);

        $display("[TB] reset mid-ramp");
        applyStimulus(1'b1, 16'd1234, "t6_edge");
        applyStimulus(1'b0, 16'd0, "t6_mid");
        asyncReset("t6_rst");
        applyStimulus(1'b1, 16'd100, "t6_edge2");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'd0, "t6_ramp");
        checkOutput("t6_final", out1, 100);

        $display("[TB] random stimulus");
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 4) == 0), 16'($urandom), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
